// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: memory geometry and session states.
package loader_pkg;
    localparam int MEM_ADDR_W = 14;
    localparam int WORD_W     = 32;
    localparam int MAX_WORDS  = 4096;
    // One extra bit so a full 4096-word length and the word counter never wrap.
    localparam int LEN_W      = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CPU_RST,
        RUN,
        DONE
    } state_e;
endpackage

// File: rtl/prog_loader_if.sv
// Host program-word stream: valid/data from the host, ready back from the loader.
interface prog_loader_if;
    import loader_pkg::*;

    logic              valid;
    logic [WORD_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prog_loader.sv
// Loads a program into shared memory, holds the CPU in reset, then runs it under
// an optional cycle watchdog and hands the memory port to the CPU while running.
module prog_loader
    import loader_pkg::*;
#(
    parameter int CPU_RST_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_start,
    input  logic [LEN_W-1:0]      i_load_len,
    input  logic [31:0]           i_cycle_limit,
    input  logic                  i_host_valid,
    input  logic [WORD_W-1:0]     i_host_data,
    output logic                  o_host_ready,
    input  logic                  i_cpu_mem_write_en,
    input  logic [MEM_ADDR_W-1:0] i_cpu_mem_addr,
    input  logic [WORD_W-1:0]     i_cpu_mem_data,
    output logic                  o_cpu_rst,
    output logic                  o_cpu_enable,
    input  logic                  i_cpu_halted,
    output logic                  o_mem_write_en,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0]     o_mem_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [31:0]           o_cycle_count
);
    localparam logic [3:0] RST_LAST = 4'(CPU_RST_CYCLES - 1);

    state_e                r_state;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_word_cnt;
    logic                  r_last;
    logic [3:0]            r_rst_cnt;
    logic [31:0]           r_limit;
    logic [31:0]           r_count;
    logic                  r_timeout;
    logic                  r_wr_en;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0]     r_data;

    logic        w_run;
    logic        w_hs;
    logic        w_limit_hit;
    logic [31:0] w_count_next;

    assign w_run        = (r_state == RUN);
    // r_last marks the drain cycle: the final word's write is still on the port.
    assign o_host_ready = (r_state == LOAD) && !r_last;
    assign w_hs         = o_host_ready && i_host_valid;
    assign w_limit_hit  = (r_limit != '0) && (r_count == r_limit - 1'b1);
    assign w_count_next = (r_count == '1) ? r_count : r_count + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_last     <= 1'b0;
            r_rst_cnt  <= '0;
            r_limit    <= '0;
            r_count    <= '0;
            r_timeout  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_load_start) begin
                        r_len      <= i_load_len;
                        r_limit    <= i_cycle_limit;
                        r_count    <= '0;
                        r_timeout  <= 1'b0;
                        r_word_cnt <= '0;
                        r_last     <= 1'b0;
                        r_rst_cnt  <= '0;
                        r_state    <= (i_load_len != '0) ? LOAD : CPU_RST;
                    end
                end
                LOAD: begin
                    if (r_last) begin
                        r_state   <= CPU_RST;
                        r_rst_cnt <= '0;
                    end else if (w_hs) begin
                        r_wr_en    <= 1'b1;
                        r_addr     <= {r_word_cnt[LEN_W-2:0], 2'b00};
                        r_data     <= i_host_data;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == r_len - 1'b1)
                            r_last <= 1'b1;
                    end
                end
                CPU_RST: begin
                    if (r_rst_cnt == RST_LAST)
                        r_state <= RUN;
                    else
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                RUN: begin
                    r_count <= w_count_next;
                    // A halt seen in the same cycle as the limit is a clean finish.
                    if (i_cpu_halted) begin
                        r_state <= DONE;
                    end else if (w_limit_hit) begin
                        r_state   <= DONE;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cpu_rst      = i_rst || (r_state == IDLE) || (r_state == CPU_RST);
    assign o_cpu_enable   = w_run;
    assign o_busy         = (r_state == LOAD) || (r_state == CPU_RST) || w_run;
    assign o_done         = (r_state == DONE);
    assign o_timeout      = r_timeout;
    assign o_cycle_count  = r_count;

    assign o_mem_write_en = w_run ? i_cpu_mem_write_en : r_wr_en;
    assign o_mem_addr     = w_run ? i_cpu_mem_addr     : r_addr;
    assign o_mem_data     = w_run ? i_cpu_mem_data     : r_data;
endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected writes and session results
// are queued by the stimulus and consumed by an independent monitor.
`timescale 1ns/1ps
module tb_prog_loader;
    import loader_pkg::*;

    localparam int RSTC = 2;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] c;
        logic        t;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [12:0] load_len;
    logic [31:0] cycle_limit;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_rst, cpu_en, cpu_halted;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy, done, timeout;
    logic [31:0] ccount;

    wr_t  wq[$];
    res_t rq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    prog_loader_if host_if ();

    prog_loader #(.CPU_RST_CYCLES(RSTC)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_load_start       (load_start),
        .i_load_len         (load_len),
        .i_cycle_limit      (cycle_limit),
        .i_host_valid       (host_if.valid),
        .i_host_data        (host_if.data),
        .o_host_ready       (host_if.ready),
        .i_cpu_mem_write_en (cpu_we),
        .i_cpu_mem_addr     (cpu_addr),
        .i_cpu_mem_data     (cpu_data),
        .o_cpu_rst          (cpu_rst),
        .o_cpu_enable       (cpu_en),
        .i_cpu_halted       (cpu_halted),
        .o_mem_write_en     (mem_we),
        .o_mem_addr         (mem_addr),
        .o_mem_data         (mem_data),
        .o_busy             (busy),
        .o_done             (done),
        .o_timeout          (timeout),
        .o_cycle_count      (ccount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // CPU memory requests change every cycle; only RUN may let them through.
    initial begin
        cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
        forever begin
            @(posedge clk); #1;
            cpu_we   = 1'($urandom % 2);
            cpu_addr = 14'($urandom);
            cpu_data = $urandom;
        end
    end

    initial begin : monitor
        int   rstlen;
        logic pen, pdone;
        wr_t  w;
        res_t r;
        rstlen = 0; pen = 1'b0; pdone = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_en) begin
                chk("mirror_we",   32'(mem_we),   32'(cpu_we));
                chk("mirror_addr", 32'(mem_addr), 32'(cpu_addr));
                chk("mirror_data", mem_data,      cpu_data);
            end else if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_data);
                end else begin
                    w = wq.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(w.a));
                    chk("write_data", mem_data, w.d);
                end
            end
            if (cpu_rst && busy && !rst) begin
                rstlen++;
                chk("cpu_rst_no_write", 32'(mem_we), 0);
            end
            if (!busy) rstlen = 0;
            if (cpu_en && !pen) begin
                chk("cpu_rst_len", 32'(rstlen), RSTC);
                rstlen = 0;
            end
            if (done && !pdone) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    r = rq.pop_front();
                    chk("done_count",   ccount,        r.c);
                    chk("done_timeout", 32'(timeout),  32'(r.t));
                end
                chk("done_enable",   32'(cpu_en),     0);
                chk("done_cpu_rst",  32'(cpu_rst),    0);
                chk("done_busy",     32'(busy),       0);
                chk("done_wq_empty", 32'(wq.size()),  0);
            end
            pen = cpu_en; pdone = done;
        end
    end

    // gm: 0 back-to-back, 1 three idle cycles between words, 2 random valid.
    // hh: RUN cycle (1-based) in which the CPU halts, 0 = never.
    task automatic run_session(input int len, input int gm, input int lim, input int hh,
                               input bit inj, input bit rst_mid, input bit fixed_data);
        int          k, cyc, gap, kmax;
        bit          v, rdy;
        logic [31:0] d;
        res_t        r;
        @(negedge clk);
        load_start  = 1'b1;
        load_len    = 13'(len);
        cycle_limit = 32'(lim);
        if (!rst_mid) begin
            if (lim != 0 && (hh == 0 || lim < hh)) begin r.c = 32'(lim); r.t = 1'b1; end
            else begin r.c = 32'(hh); r.t = 1'b0; end
            rq.push_back(r);
        end
        @(posedge clk); #1;
        load_start = 1'b0;
        k = 0; cyc = 0; gap = 0;
        kmax = rst_mid ? 2 : len;
        while (k < kmax && cyc < 4 * len + 50) begin
            @(negedge clk);
            rdy = host_if.ready;
            case (gm)
                0:       v = 1'b1;
                1:       v = (gap == 0);
                default: v = 1'($urandom % 2);
            endcase
            if (gm == 1 && !v) gap--;
            d = fixed_data ? 32'(32'hA + k) : $urandom;
            host_if.valid = v;
            host_if.data  = d;
            @(posedge clk); #1;
            if (v && rdy) begin
                w_push(14'(4 * k), d);
                k++;
                gap = 3;
            end
            cyc++;
        end
        host_if.valid = 1'b0;
        chk("load_words", 32'(k), 32'(kmax));
        if (rst_mid) begin
            rst = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("abort_busy",    32'(busy),            0);
            chk("abort_we",      32'(mem_we),          0);
            chk("abort_ready",   32'(host_if.ready),   0);
            chk("abort_cpu_rst", 32'(cpu_rst),         1);
            chk("abort_wq",      32'(wq.size()),       0);
            rst = 1'b0;
        end else begin
            cyc = 0;
            while (cyc < 400) begin
                @(negedge clk);
                if (done) break;
                cpu_halted = cpu_en && (hh != 0) && (ccount == 32'(hh - 1));
                load_start = inj && cpu_en && (ccount == 32'd1);
                if (load_start) load_len = 13'd7;
                cyc++;
            end
            cpu_halted = 1'b0;
            load_start = 1'b0;
            chk("done_reached", 32'(done), 1);
        end
    endtask

    task automatic w_push(input logic [13:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wq.push_back(w);
    endtask

    initial begin : stim
        rst = 1'b1; load_start = 1'b0; load_len = '0; cycle_limit = '0; cpu_halted = 1'b0;
        host_if.valid = 1'b0; host_if.data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(host_if.ready), 0);
        chk("rst_we",      32'(mem_we),        0);
        chk("rst_addr",    32'(mem_addr),      0);
        chk("rst_data",    mem_data,           0);
        chk("rst_enable",  32'(cpu_en),        0);
        chk("rst_done",    32'(done),          0);
        chk("rst_timeout", 32'(timeout),       0);
        chk("rst_count",   ccount,             0);
        chk("rst_cpu_rst", 32'(cpu_rst),       1);
        chk("rst_busy",    32'(busy),          0);
        rst = 1'b0;

        run_session(3,    0, 0, 10, 1'b0, 1'b0, 1'b1);
        run_session(2,    1, 0, 10, 1'b0, 1'b0, 1'b0);
        run_session(0,    0, 5, 0,  1'b1, 1'b0, 1'b0);
        run_session(1,    2, 5, 5,  1'b0, 1'b0, 1'b0);
        run_session(4,    0, 0, 0,  1'b0, 1'b1, 1'b0);
        run_session(4,    2, 0, 3,  1'b0, 1'b0, 1'b0);
        run_session(4096, 0, 1, 0,  1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_session(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 12)), int'($urandom_range(1, 15)),
                        1'($urandom % 2), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("rq_empty", 32'(rq.size()), 0);
        chk("wq_empty", 32'(wq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
